// File: rtl/sd_spi_card_responder.sv
// SPI-mode SD card target: decodes host commands and serves CMD17 reads from a byte memory.
// Define SD_RESP_CRC_CHECK_EN to check command CRC7 and send a CRC16 of each data block.
module sd_spi_card_responder #(
    parameter int INIT_POLLS = 2,
    parameter int MEM_AW     = 16,
    parameter int MEM_LAT    = 2
) (
    input  logic              iCLK,
    input  logic              Reset,
    input  logic              SD_CLK,
    input  logic              SD_CS,
    input  logic              SD_MOSI,
    output logic              SD_MISO,
    output logic [MEM_AW-1:0] oMemAddr,
    input  logic [7:0]        iMemData,
    output logic              oIdle
);

    typedef enum logic [3:0] {
        HUNT, CMD, NCR, R1, RX_EXT, RD_NAC, TOKEN, DATA, CRC
    } state_t;

    typedef enum logic [1:0] {P_NONE, P_R7, P_R3, P_READ} post_t;

    localparam logic [3:0] MEM_LAT_W = 4'(MEM_LAT);

    state_t      state, state_n;
    post_t       post, post_n;
    logic [2:0]  sclk_s, cs_s;
    logic [1:0]  mosi_s;
    logic        sclk_rise, sclk_fall, cs_hi, byte_done;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_sr;
    logic [7:0]  rx_byte, tx_sr, tx_n, r1_val, crc_hi, crc_lo;
    logic [8:0]  cnt, cnt_n;
    logic [5:0]  cmd_idx;
    logic [31:0] arg, ext_word;
    logic [15:0] polls, polls_n;
    logic        app, app_n, idle_n, exec, addr_set, addr_inc, crc_bad;
    logic [40:0] base;
    logic        unused_bits;

    function automatic logic [7:0] ext_byte(input logic [31:0] w, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0: b = w[31:24];
            2'd1: b = w[23:16];
            2'd2: b = w[15:8];
            2'd3: b = w[7:0];
        endcase
        return b;
    endfunction

`ifdef SD_RESP_CRC_CHECK_EN
    logic [7:0]  crc_rx;
    logic [15:0] crc16;

    function automatic logic [6:0] crc7_f(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--)
            c = (c[6] ^ d[i]) ? ({c[5:0], 1'b0} ^ 7'h09) : {c[5:0], 1'b0};
        return c;
    endfunction

    function automatic logic [15:0] crc16_f(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++)
            r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
        return r;
    endfunction

    assign crc_bad = crc7_f({2'b01, cmd_idx, arg}) != crc_rx[7:1];
    assign crc_hi  = crc16[15:8];
    assign crc_lo  = crc16[7:0];
    assign unused_bits = ^{base, arg, crc_rx[0], MEM_LAT_W};

    always_ff @(posedge iCLK) begin
        if (Reset) begin
            crc_rx <= '0;
            crc16  <= '0;
        end else begin
            if (byte_done && state == CMD && cnt == 9'd4)
                crc_rx <= rx_byte;
            if (addr_set)
                crc16 <= '0;
            else if (addr_inc)
                crc16 <= crc16_f(crc16, iMemData);
        end
    end
`else
    assign crc_bad = 1'b0;
    assign crc_hi  = 8'hFF;
    assign crc_lo  = 8'hFF;
    assign unused_bits = ^{base, arg, MEM_LAT_W};
`endif

    assign sclk_rise = sclk_s[1] & ~sclk_s[2];
    assign sclk_fall = ~sclk_s[1] & sclk_s[2];
    assign cs_hi     = cs_s[1];
    assign rx_byte   = {rx_sr, mosi_s[1]};
    assign byte_done = sclk_rise & ~cs_hi & (bit_cnt == 3'd7);
    assign base      = {arg, 9'd0};
    assign ext_word  = (post == P_R7) ? {24'h000001, arg[7:0]} : 32'hC0FF8000;

    // Command execution, evaluated when the R1 byte is loaded
    always_comb begin
        r1_val  = {7'd0, oIdle};
        post_n  = P_NONE;
        idle_n  = oIdle;
        polls_n = polls;
        app_n   = 1'b0;
        if (crc_bad) begin
            r1_val = {4'd0, 1'b1, 2'd0, oIdle};
            app_n  = app;
        end else if (app) begin
            if (cmd_idx == 6'd41) begin
                if (polls < 16'(INIT_POLLS)) begin
                    r1_val  = 8'h01;
                    polls_n = polls + 16'd1;
                end else begin
                    r1_val = 8'h00;
                    idle_n = 1'b0;
                end
            end else begin
                r1_val = {5'd0, 1'b1, 1'b0, oIdle};
            end
        end else begin
            unique case (1'b1)
                cmd_idx == 6'd0: begin
                    r1_val  = 8'h01;
                    idle_n  = 1'b1;
                    polls_n = '0;
                end
                cmd_idx == 6'd8:  post_n = P_R7;
                cmd_idx == 6'd16: post_n = P_NONE;
                cmd_idx == 6'd17: begin
                    r1_val = oIdle ? 8'h05 : 8'h00;
                    post_n = oIdle ? P_NONE : P_READ;
                end
                cmd_idx == 6'd55: app_n = 1'b1;
                cmd_idx == 6'd58: post_n = P_R3;
                default: r1_val = {5'd0, 1'b1, 1'b0, oIdle};
            endcase
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        tx_n     = 8'hFF;
        exec     = 1'b0;
        addr_set = 1'b0;
        addr_inc = 1'b0;
        if (cs_hi) begin
            state_n = HUNT;
        end else if (byte_done) begin
            unique case (state)
                HUNT: if (rx_byte[7:6] == 2'b01) begin
                    state_n = CMD;
                    cnt_n   = '0;
                end
                CMD: if (cnt == 9'd4) state_n = NCR;
                     else cnt_n = cnt + 9'd1;
                NCR: begin
                    state_n = R1;
                    tx_n    = r1_val;
                    exec    = 1'b1;
                end
                R1: begin
                    cnt_n = '0;
                    unique case (post)
                        P_R7, P_R3: begin
                            state_n = RX_EXT;
                            tx_n    = ext_byte(ext_word, 2'd0);
                        end
                        P_READ:  state_n = RD_NAC;
                        default: state_n = HUNT;
                    endcase
                end
                RX_EXT: if (cnt == 9'd3) begin
                    state_n = HUNT;
                end else begin
                    cnt_n = cnt + 9'd1;
                    tx_n  = ext_byte(ext_word, cnt[1:0] + 2'd1);
                end
                RD_NAC: begin
                    state_n  = TOKEN;
                    tx_n     = 8'hFE;
                    addr_set = 1'b1;
                end
                TOKEN: begin
                    state_n  = DATA;
                    cnt_n    = '0;
                    tx_n     = iMemData;
                    addr_inc = 1'b1;
                end
                DATA: if (cnt == 9'd511) begin
                    state_n = CRC;
                    cnt_n   = '0;
                    tx_n    = crc_hi;
                end else begin
                    cnt_n    = cnt + 9'd1;
                    tx_n     = iMemData;
                    addr_inc = 1'b1;
                end
                CRC: if (cnt == 9'd0) begin
                    cnt_n = 9'd1;
                    tx_n  = crc_lo;
                end else begin
                    state_n = HUNT;
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (Reset) begin
            state <= HUNT;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge iCLK) begin
        if (Reset) begin
            sclk_s <= '0;
            cs_s   <= '1;
            mosi_s <= '0;
        end else begin
            sclk_s <= {sclk_s[1:0], SD_CLK};
            cs_s   <= {cs_s[1:0], SD_CS};
            mosi_s <= {mosi_s[0], SD_MOSI};
        end
    end

    always_ff @(posedge iCLK) begin
        if (Reset) begin
            bit_cnt  <= '0;
            rx_sr    <= '0;
            tx_sr    <= 8'hFF;
            SD_MISO  <= 1'b1;
            cmd_idx  <= '0;
            arg      <= '0;
            post     <= P_NONE;
            app      <= 1'b0;
            polls    <= '0;
            oIdle    <= 1'b1;
            oMemAddr <= '0;
        end else if (cs_hi) begin
            bit_cnt <= '0;
            tx_sr   <= 8'hFF;
            SD_MISO <= 1'b1;
        end else begin
            if (sclk_rise) begin
                rx_sr   <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
            end
            // MISO moves on the falling edge so the host samples it stable on the rise
            if (byte_done)
                tx_sr <= tx_n;
            else if (sclk_fall) begin
                SD_MISO <= tx_sr[7];
                tx_sr   <= {tx_sr[6:0], 1'b1};
            end
            if (byte_done && state == HUNT)
                cmd_idx <= rx_byte[5:0];
            if (byte_done && state == CMD && cnt != 9'd4)
                arg <= {arg[23:0], rx_byte};
            if (exec) begin
                post  <= post_n;
                app   <= app_n;
                polls <= polls_n;
                oIdle <= idle_n;
            end
            if (addr_set)
                oMemAddr <= base[MEM_AW-1:0];
            else if (addr_inc)
                oMemAddr <= oMemAddr + MEM_AW'(1);
        end
    end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Bench for sd_spi_card_responder: directed and random SPI command traffic
// compared byte by byte against a behavioural card model.
`timescale 1ns/1ps
module tb_sd_spi_card_responder;

    logic        iCLK = 1'b0;
    logic        Reset, SD_CLK, SD_CS, SD_MOSI, SD_MISO, oIdle;
    logic [15:0] oMemAddr;
    logic [7:0]  iMemData = 8'h00;
    logic [7:0]  mem_d1 = 8'h00;

    int n_vec = 0;
    int n_bad = 0;
    int mem_mode = 0;
    int cs_hi_cnt = 0;
    int m_polls = 0;
    bit m_idle = 1'b1;
    bit m_app = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    sd_spi_card_responder #(
        .INIT_POLLS(2),
        .MEM_AW(16),
        .MEM_LAT(2)
    ) dut (
        .iCLK(iCLK),
        .Reset(Reset),
        .SD_CLK(SD_CLK),
        .SD_CS(SD_CS),
        .SD_MOSI(SD_MOSI),
        .SD_MISO(SD_MISO),
        .oMemAddr(oMemAddr),
        .iMemData(iMemData),
        .oIdle(oIdle)
    );

    always #5 iCLK = ~iCLK;

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        logic [7:0] h;
        h = 8'(a[15:8] * 8'd37);
        return (mem_mode == 0) ? a[7:0] : (a[7:0] ^ h);
    endfunction

    // Two-cycle read latency memory
    always @(posedge iCLK) begin
        mem_d1   <= mem_f(oMemAddr);
        iMemData <= mem_d1;
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // MISO must sit high whenever the card is deselected
    always @(negedge iCLK) begin
        if (SD_CS === 1'b1) cs_hi_cnt++;
        else cs_hi_cnt = 0;
        if (cs_hi_cnt > 4 && Reset === 1'b0)
            chk("miso_cs_high", 16'(SD_MISO), 16'h1);
    end

    function automatic logic [6:0] crc7_f(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            if (c[6] ^ d[i]) c = {c[5:0], 1'b0} ^ 7'h09;
            else c = {c[5:0], 1'b0};
        end
        return c;
    endfunction

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            SD_MOSI = tx[i];
            #40;
            rx[i] = SD_MISO;
            SD_CLK = 1'b1;
            #40;
            SD_CLK = 1'b0;
        end
    endtask

    // Expected bytes after the command frame: NCR filler, R1, then any payload
    task automatic model_cmd(input int idx, input logic [31:0] arg);
        logic [7:0]  r1;
        logic [15:0] base;
        bit          was_app;
        exp_q.delete();
        exp_q.push_back(8'hFF);
        was_app = m_app;
        m_app = 1'b0;
        r1 = {7'd0, m_idle};
        if (was_app) begin
            if (idx == 41) begin
                if (m_polls < 2) begin
                    r1 = 8'h01;
                    m_polls++;
                end else begin
                    r1 = 8'h00;
                    m_idle = 1'b0;
                end
            end else begin
                r1 = 8'h04 | {7'd0, m_idle};
            end
            exp_q.push_back(r1);
        end else begin
            case (idx)
                0: begin
                    m_idle = 1'b1;
                    m_polls = 0;
                    exp_q.push_back(8'h01);
                end
                8: begin
                    exp_q.push_back(r1);
                    exp_q.push_back(8'h00);
                    exp_q.push_back(8'h00);
                    exp_q.push_back(8'h01);
                    exp_q.push_back(arg[7:0]);
                end
                16: exp_q.push_back(r1);
                17: begin
                    if (m_idle) begin
                        exp_q.push_back(8'h05);
                    end else begin
                        exp_q.push_back(8'h00);
                        exp_q.push_back(8'hFF);
                        exp_q.push_back(8'hFE);
                        base = 16'(arg << 9);
                        for (int i = 0; i < 512; i++)
                            exp_q.push_back(mem_f(base + 16'(i)));
                        exp_q.push_back(8'hFF);
                        exp_q.push_back(8'hFF);
                    end
                end
                55: begin
                    exp_q.push_back(r1);
                    m_app = 1'b1;
                end
                58: begin
                    exp_q.push_back(r1);
                    exp_q.push_back(8'hC0);
                    exp_q.push_back(8'hFF);
                    exp_q.push_back(8'h80);
                    exp_q.push_back(8'h00);
                end
                default: exp_q.push_back(8'h04 | {7'd0, m_idle});
            endcase
        end
    endtask

    task automatic do_cmd(input int idx, input logic [31:0] arg, input int stop_at, input string nm);
        logic [7:0]  rx;
        logic [39:0] body;
        body = {2'b01, 6'(idx), arg};
        model_cmd(idx, arg);
        got_q.delete();
        if (SD_CS) begin
            SD_CS = 1'b0;
            #80;
        end
        for (int b = 0; b < 5; b++) begin
            xfer(body[39-8*b -: 8], rx);
            chk({nm, "_frame"}, 16'(rx), 16'hFF);
        end
        xfer({crc7_f(body), 1'b1}, rx);
        chk({nm, "_frame"}, 16'(rx), 16'hFF);
        for (int k = 0; k < exp_q.size() && k < stop_at; k++) begin
            xfer(8'hFF, rx);
            got_q.push_back(rx);
            chk($sformatf("%s_rsp%0d", nm, k), 16'(rx), 16'(exp_q[k]));
        end
        if (stop_at < exp_q.size()) begin
            SD_CS = 1'b1;
            #200;
        end else begin
            xfer(8'hFF, rx);
            chk({nm, "_hunt"}, 16'(rx), 16'hFF);
        end
        chk({nm, "_idle"}, 16'(oIdle), 16'(m_idle));
    endtask

    initial begin
        Reset = 1'b1;
        SD_CS = 1'b1;
        SD_CLK = 1'b0;
        SD_MOSI = 1'b1;
        #52;
        chk("rst_miso", 16'(SD_MISO), 16'h1);
        chk("rst_addr", oMemAddr, 16'h0);
        chk("rst_idle", 16'(oIdle), 16'h1);
        chk("crc7_cmd0", 16'({crc7_f(40'h4000000000), 1'b1}), 16'h95);
        chk("crc7_cmd8", 16'({crc7_f(40'h48000001AA), 1'b1}), 16'h87);
        Reset = 1'b0;
        #80;

        do_cmd(0, 32'h0, 1000, "cmd0");
        chk("cmd0_lit", 16'(got_q[1]), 16'h01);
        do_cmd(8, 32'h1AA, 1000, "cmd8");
        chk("cmd8_lit_r1", 16'(got_q[1]), 16'h01);
        chk("cmd8_lit_aa", 16'(got_q[5]), 16'hAA);
        do_cmd(58, 32'h0, 1000, "cmd58");
        chk("cmd58_lit_c0", 16'(got_q[2]), 16'hC0);
        chk("cmd58_lit_80", 16'(got_q[4]), 16'h80);
        do_cmd(17, 32'h1, 1000, "cmd17_idle");
        chk("cmd17_idle_lit", 16'(got_q[1]), 16'h05);
        do_cmd(5, 32'h0, 1000, "cmd5");
        chk("cmd5_lit", 16'(got_q[1]), 16'h05);

        for (int p = 0; p < 3; p++) begin
            do_cmd(55, 32'h0, 1000, "cmd55");
            do_cmd(41, 32'h40000000, 1000, "acmd41");
            chk($sformatf("acmd41_lit%0d", p), 16'(got_q[1]), (p < 2) ? 16'h01 : 16'h00);
        end
        chk("ready_lit", 16'(oIdle), 16'h0);

        mem_mode = 0;
        do_cmd(17, 32'h1, 1000, "read1");
        chk("read1_r1", 16'(got_q[1]), 16'h00);
        chk("read1_tok", 16'(got_q[3]), 16'hFE);
        chk("read1_d0", 16'(got_q[4]), 16'h00);
        chk("read1_d255", 16'(got_q[259]), 16'hFF);
        chk("read1_d256", 16'(got_q[260]), 16'h00);
        chk("read1_crc", 16'(got_q[516]), 16'hFF);
        chk("read1_addr", oMemAddr, 16'd1024);

        mem_mode = 1;
        do_cmd(17, $urandom(), 104, "read_abort");
        do_cmd(0, 32'h0, 1000, "cmd0_after_abort");
        chk("abort_cmd0_lit", 16'(got_q[1]), 16'h01);
        chk("abort_idle_lit", 16'(oIdle), 16'h1);

        for (int it = 0; it < 12; it++) begin
            int sel;
            int idx;
            logic [31:0] a;
            sel = $urandom_range(0, 7);
            a = $urandom();
            case (sel)
                0: idx = 0;
                1: idx = 8;
                2: idx = 55;
                3: idx = 41;
                4: idx = 16;
                5: idx = 58;
                6: idx = 17;
                default: idx = $urandom_range(0, 63);
            endcase
            if (idx == 17 && !m_idle) idx = 16;
            if ($urandom_range(0, 3) == 0) begin
                SD_CS = 1'b1;
                #200;
            end
            do_cmd(idx, a, 1000, "rnd");
            if (idx == 55 && $urandom_range(0, 1) == 1)
                do_cmd(41, a, 1000, "rnd_acmd41");
        end

        SD_CS = 1'b1;
        #200;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
